core_cp15: RTL and testbench
============================

Name: core_cp15

Overview:
- System-control coprocessor (CP15) execute unit, directly downstream of the coprocessor decoder.
- Consumes the decoded MRC/MCR fields (crn, crm, op1, op2, load) plus the ARM register value for MCR.
- Holds the CP15 register state (ID, SCTLR, TTBR, DACR, FSR, FAR) and runs multi-cycle cache/TLB maintenance through a request/acknowledge handshake with the memory subsystem.
- Returns MRC read data and a one-cycle completion pulse to the pipeline.

Parameters:
- ID_CODE, 32'h4100_0000, constant returned for c0/op2=0 reads.
- SCTLR_RESET, 32'h0000_0000, SCTLR reset value; bit 0 = M, bit 1 = A, bit 2 = C, bit 13 = V.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- transfer  in  1  one-cycle start strobe; dec and write are valid in this cycle.
- dec  in  coproc_decode  decoded crn/crm/op1/op2/load.
- write  in  32  ARM register value for MCR.
- read  out  32  MRC result, valid while done=1.
- done  out  1  one-cycle completion pulse.
- undefined  out  1  qualifies done; the access is unimplemented and the pipeline takes the undefined-instruction trap.
- busy  out  1  a transfer is in progress.
- mmu_enable, align_check, cache_enable, high_vectors  out  1 each  SCTLR bits 0, 1, 2, 13.
- ttbr  out  32  translation table base; bits [13:0] always read 0.
- dacr  out  32  domain access control.
- fault  in  1  MMU abort capture strobe.
- fault_status  in  8  {domain[3:0], status[3:0]}.
- fault_addr  in  32  faulting virtual address.
- flush_req  out  1  maintenance request, level-held.
- flush_op  out  2  00 = invalidate I-cache, 01 = invalidate D-cache, 10 = invalidate TLB, 11 = invalidate all.
- flush_ack  in  1  one-cycle acknowledge from the memory subsystem.

Behaviour:
- Reset values: read=0, done=0, undefined=0, busy=0, flush_req=0, flush_op=0, SCTLR=SCTLR_RESET, ttbr=0, dacr=0, FSR=0, FAR=0. FSM = IDLE.
- FSM states: IDLE, COMMIT, FLUSH, ACKED.
- IDLE + transfer, normal access:
  - State goes to COMMIT and busy=1 from the next cycle.
  - The register write (MCR) or read capture (MRC) happens on the COMMIT cycle.
  - done pulses in the cycle after COMMIT, so latency from transfer to done is 2 cycles. FSM then returns to IDLE.
- IDLE + transfer, maintenance (MCR to crn=7 or crn=8 with a valid crm/op2):
  - State goes to FLUSH; flush_req=1 and flush_op are held stable until flush_ack.
  - flush_ack in FLUSH: flush_req drops in the next cycle, state goes to ACKED, then done pulses and the FSM returns to IDLE.
  - flush_ack outside FLUSH is ignored.
- Register map (op1 must be 0, otherwise undefined):
  - c0/crm0/op2=0: read ID_CODE. Writes are ignored, not undefined.
  - c1/crm0/op2=0: SCTLR read/write. Only bits 0, 1, 2, 13 are writable; other bits read 0.
  - c2/crm0/op2=0: TTBR. Write masks bits [13:0] to 0.
  - c3/crm0/op2=0: DACR, full 32-bit read/write.
  - c5/crm0/op2=0: FSR. Bits [7:0] are read/write; bits [31:8] read 0.
  - c6/crm0/op2=0: FAR, full 32-bit read/write.
  - c7 maintenance, write only:
    - crm5/op2=0 -> flush_op 00.
    - crm6/op2=0 -> flush_op 01.
    - crm7/op2=0 -> flush_op 11.
  - c8 maintenance, write only: crm7/op2=0 -> flush_op 10.
  - MRC from c7 or c8 is undefined.
  - Any other encoding: undefined=1 together with done, 2-cycle latency, no state change, read=0.
- read is 0 whenever done=0.
- fault capture:
  - Any cycle with fault=1 loads FSR <= fault_status and FAR <= fault_addr.
  - If an MCR to c5 or c6 commits in the same cycle, fault wins.
- A transfer while busy=1 is a protocol violation: it is ignored and flagged by an assertion.
- Reset asserted mid-FLUSH: FSM returns to IDLE and flush_req drops immediately (async reset). No done pulse is issued.
- SCTLR and ttbr/dacr outputs reflect a write from the cycle after COMMIT.

Decomposition:
- Shared package (uarch/isa), to be added:
  - CP15 crn constants: CP15_ID, CP15_CTRL, CP15_TTBR, CP15_DACR, CP15_FSR, CP15_FAR, CP15_CACHE, CP15_TLB.
  - SCTLR bit-position constants.
  - Enum cp15_flush_op.
  - Enum cp15_state.
- One sub-module, core_cp15_maint: owns the FLUSH/ACKED handshake and flush_op encoding, and exposes start/done to the main FSM.

Test Plan:
- MCR c1 write=32'hFFFF_FFFF, then MRC c1 -> each done arrives 2 cycles after its transfer; read=32'h0000_2007; mmu_enable=align_check=cache_enable=high_vectors=1.
- MCR c2 write=32'h1234_5FFF -> ttbr=32'h1234_4000; MRC c2 returns the same value.
- MCR c8 crm7 op2=0 with flush_ack delayed 5 cycles -> flush_req high for 5 cycles with flush_op=10, busy=1 throughout, done exactly 2 cycles after flush_ack.
- fault=1 (status 8'h35, addr 32'hDEAD_BEEF) in the same cycle as an MCR c6 COMMIT with write=0 -> FAR=32'hDEAD_BEEF, FSR=8'h35.
- MRC with op1=1, and separately MRC c7 -> done with undefined=1, read=0, all register state unchanged.
- rst asserted while in FLUSH -> flush_req=0 immediately; no done pulse; a subsequent MRC c0 returns ID_CODE.

Source files
------------

// File: rtl/core_cp15_pkg.sv
// ============================================================================
//  Module      : core_cp15_pkg
//  Description : Shared types, constants and decode helper for the CP15
//                system-control coprocessor execute unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_cp15_pkg;

  // Decoded MRC/MCR fields handed over by the coprocessor decoder.
  // load=1 is an MRC (coprocessor -> ARM register), load=0 is an MCR.
  typedef struct packed {
    logic [3:0] crn;
    logic [3:0] crm;
    logic [2:0] op1;
    logic [2:0] op2;
    logic       load;
  } coproc_decode;

  // Primary register numbers (crn)
  localparam logic [3:0] CP15_ID    = 4'd0;
  localparam logic [3:0] CP15_CTRL  = 4'd1;
  localparam logic [3:0] CP15_TTBR  = 4'd2;
  localparam logic [3:0] CP15_DACR  = 4'd3;
  localparam logic [3:0] CP15_FSR   = 4'd5;
  localparam logic [3:0] CP15_FAR   = 4'd6;
  localparam logic [3:0] CP15_CACHE = 4'd7;
  localparam logic [3:0] CP15_TLB   = 4'd8;

  // SCTLR bit positions
  localparam int SCTLR_M = 0;
  localparam int SCTLR_A = 1;
  localparam int SCTLR_C = 2;
  localparam int SCTLR_V = 13;

  // Implemented SCTLR bits; everything else is read-as-zero
  localparam logic [31:0] SCTLR_MASK = (32'd1 << SCTLR_M) | (32'd1 << SCTLR_A) |
                                       (32'd1 << SCTLR_C) | (32'd1 << SCTLR_V);
  // Translation table base is 16 KB aligned
  localparam logic [31:0] TTBR_MASK  = 32'hFFFF_C000;

  typedef enum logic [1:0] {
    FLUSH_ICACHE = 2'b00,
    FLUSH_DCACHE = 2'b01,
    FLUSH_TLB    = 2'b10,
    FLUSH_ALL    = 2'b11
  } cp15_flush_op;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_ACKED  = 2'd3
  } cp15_state;

  // Which architectural target an access resolves to
  typedef enum logic [2:0] {
    ACC_UNDEF = 3'd0,
    ACC_ID    = 3'd1,
    ACC_CTRL  = 3'd2,
    ACC_TTBR  = 3'd3,
    ACC_DACR  = 3'd4,
    ACC_FSR   = 3'd5,
    ACC_FAR   = 3'd6,
    ACC_MAINT = 3'd7
  } cp15_access;

  typedef struct packed {
    cp15_access   acc;
    cp15_flush_op op;
  } cp15_target;

  // Resolve a decoded access to its target; unknown encodings map to ACC_UNDEF
  function automatic cp15_target cp15_classify(input coproc_decode d);
    cp15_target t;
    logic       plain;
    t.acc = ACC_UNDEF;
    t.op  = FLUSH_ICACHE;
    plain = (d.crm == 4'd0) && (d.op2 == 3'd0);
    if (d.op1 == 3'd0) begin
      case (d.crn)
        CP15_ID:   if (plain) t.acc = ACC_ID;
        CP15_CTRL: if (plain) t.acc = ACC_CTRL;
        CP15_TTBR: if (plain) t.acc = ACC_TTBR;
        CP15_DACR: if (plain) t.acc = ACC_DACR;
        CP15_FSR:  if (plain) t.acc = ACC_FSR;
        CP15_FAR:  if (plain) t.acc = ACC_FAR;
        CP15_CACHE: begin
          if (!d.load && (d.op2 == 3'd0)) begin
            case (d.crm)
              4'd5: begin t.acc = ACC_MAINT; t.op = FLUSH_ICACHE; end
              4'd6: begin t.acc = ACC_MAINT; t.op = FLUSH_DCACHE; end
              4'd7: begin t.acc = ACC_MAINT; t.op = FLUSH_ALL;    end
              default: ;
            endcase
          end
        end
        CP15_TLB: begin
          if (!d.load && (d.op2 == 3'd0) && (d.crm == 4'd7)) begin
            t.acc = ACC_MAINT;
            t.op  = FLUSH_TLB;
          end
        end
        default: ;
      endcase
    end
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_cp15_maint.sv
// ============================================================================
//  Module      : core_cp15_maint
//  Description : Cache/TLB maintenance handshake. Holds flush_req and
//                flush_op until the memory subsystem acknowledges, then
//                spends one ACKED cycle reporting completion.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_cp15_maint
  import core_cp15_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  cp15_flush_op op_in,
  input  logic         flush_ack,
  output logic         flush_req,
  output logic [1:0]   flush_op,
  output logic         done
);

  cp15_state    state_q, state_d;
  cp15_flush_op op_q, op_d;

  // State and operation registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= FLUSH_ICACHE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next state: an ack only counts while a request is outstanding
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FLUSH;
          op_d    = op_in;
        end
      end
      ST_FLUSH: if (flush_ack) state_d = ST_ACKED;
      ST_ACKED: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    flush_req = (state_q == ST_FLUSH);
    flush_op  = op_q;
    done      = (state_q == ST_ACKED);
  end

endmodule

`default_nettype wire

// File: rtl/core_cp15.sv
// ============================================================================
//  Module      : core_cp15
//  Description : CP15 system-control coprocessor execute unit. Holds ID,
//                SCTLR, TTBR, DACR, FSR and FAR, services MRC/MCR with a
//                fixed two-cycle latency and delegates cache/TLB
//                maintenance to core_cp15_maint.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_cp15
  import core_cp15_pkg::*;
#(
  parameter logic [31:0] ID_CODE     = 32'h4100_0000,
  parameter logic [31:0] SCTLR_RESET = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         transfer,
  input  coproc_decode dec,
  input  logic [31:0]  write,
  output logic [31:0]  read,
  output logic         done,
  output logic         undefined,
  output logic         busy,
  output logic         mmu_enable,
  output logic         align_check,
  output logic         cache_enable,
  output logic         high_vectors,
  output logic [31:0]  ttbr,
  output logic [31:0]  dacr,
  input  logic         fault,
  input  logic [7:0]   fault_status,
  input  logic [31:0]  fault_addr,
  output logic         flush_req,
  output logic [1:0]   flush_op,
  input  logic         flush_ack
);

  cp15_state   state_q, state_d;
  cp15_target  dec_tgt;
  cp15_access  acc_q, acc_d;
  logic        load_q, load_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] sctlr_q, sctlr_d;
  logic [31:0] ttbr_q, ttbr_d;
  logic [31:0] dacr_q, dacr_d;
  logic [7:0]  fsr_q, fsr_d;
  logic [31:0] far_q, far_d;
  logic [31:0] read_q, read_d;
  logic        done_q, done_d;
  logic        undef_q, undef_d;
  logic [31:0] rd_mux;
  logic        maint_start;
  logic        maint_done;

  // Classify the incoming decode so IDLE can choose COMMIT or FLUSH
  always_comb dec_tgt = cp15_classify(dec);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; FLUSH covers the whole handshake, whose ACKED phase lives in the sub-module
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer) state_d = (dec_tgt.acc == ACC_MAINT) ? ST_FLUSH : ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_FLUSH:  if (maint_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: completion, undefined flag and read data are registered one cycle later
  always_comb begin
    busy        = (state_q != ST_IDLE);
    maint_start = 1'b0;
    done_d      = 1'b0;
    undef_d     = 1'b0;
    read_d      = 32'd0;
    case (state_q)
      ST_IDLE:   maint_start = transfer && (dec_tgt.acc == ACC_MAINT);
      ST_COMMIT: begin
        done_d  = 1'b1;
        undef_d = (acc_q == ACC_UNDEF);
        if (load_q) read_d = rd_mux;
      end
      ST_FLUSH:  done_d = maint_done;
      default:   ;
    endcase
  end

  // Read mux over the current register values
  always_comb begin
    rd_mux = 32'd0;
    case (acc_q)
      ACC_ID:   rd_mux = ID_CODE;
      ACC_CTRL: rd_mux = sctlr_q;
      ACC_TTBR: rd_mux = ttbr_q;
      ACC_DACR: rd_mux = dacr_q;
      ACC_FSR:  rd_mux = {24'd0, fsr_q};
      ACC_FAR:  rd_mux = far_q;
      default:  rd_mux = 32'd0;
    endcase
  end

  // Latch the access on acceptance and compute register updates; a fault overrides an MCR to FSR/FAR
  always_comb begin
    acc_d   = acc_q;
    load_d  = load_q;
    wdata_d = wdata_q;
    sctlr_d = sctlr_q;
    ttbr_d  = ttbr_q;
    dacr_d  = dacr_q;
    fsr_d   = fsr_q;
    far_d   = far_q;
    if ((state_q == ST_IDLE) && transfer) begin
      acc_d   = dec_tgt.acc;
      load_d  = dec.load;
      wdata_d = write;
    end
    if ((state_q == ST_COMMIT) && !load_q) begin
      case (acc_q)
        ACC_CTRL: sctlr_d = wdata_q & SCTLR_MASK;
        ACC_TTBR: ttbr_d  = wdata_q & TTBR_MASK;
        ACC_DACR: dacr_d  = wdata_q;
        ACC_FSR:  fsr_d   = wdata_q[7:0];
        ACC_FAR:  far_d   = wdata_q;
        default:  ;
      endcase
    end
    if (fault) begin
      fsr_d = fault_status;
      far_d = fault_addr;
    end
  end

  // Datapath and architectural register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= ACC_UNDEF;
      load_q  <= 1'b0;
      wdata_q <= 32'd0;
      sctlr_q <= SCTLR_RESET & SCTLR_MASK;
      ttbr_q  <= 32'd0;
      dacr_q  <= 32'd0;
      fsr_q   <= 8'd0;
      far_q   <= 32'd0;
      read_q  <= 32'd0;
      done_q  <= 1'b0;
      undef_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      sctlr_q <= sctlr_d;
      ttbr_q  <= ttbr_d;
      dacr_q  <= dacr_d;
      fsr_q   <= fsr_d;
      far_q   <= far_d;
      read_q  <= read_d;
      done_q  <= done_d;
      undef_q <= undef_d;
    end
  end

  core_cp15_maint u_maint (
    .clk       (clk),
    .rst       (rst),
    .start     (maint_start),
    .op_in     (dec_tgt.op),
    .flush_ack (flush_ack),
    .flush_req (flush_req),
    .flush_op  (flush_op),
    .done      (maint_done)
  );

  assign read         = read_q;
  assign done         = done_q;
  assign undefined    = undef_q;
  assign mmu_enable   = sctlr_q[SCTLR_M];
  assign align_check  = sctlr_q[SCTLR_A];
  assign cache_enable = sctlr_q[SCTLR_C];
  assign high_vectors = sctlr_q[SCTLR_V];
  assign ttbr         = ttbr_q;
  assign dacr         = dacr_q;

  // A new transfer may only arrive while the unit is idle
  a_no_transfer_while_busy: assert property (@(posedge clk) disable iff (rst) !(transfer && busy));

endmodule

`default_nettype wire

// File: tb/tb_core_cp15.sv
// ============================================================================
//  Module      : tb_core_cp15
//  Description : Self-checking bench for core_cp15 with directed scenarios
//                and randomized MRC/MCR traffic against a register model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_core_cp15;
  import core_cp15_pkg::*;

  localparam logic [31:0] ID_VAL = 32'h4100_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         transfer = 1'b0;
  coproc_decode dec = '0;
  logic [31:0]  write = 32'd0;
  logic [31:0]  read;
  logic         done, undefined, busy;
  logic         mmu_enable, align_check, cache_enable, high_vectors;
  logic [31:0]  ttbr, dacr;
  logic         fault = 1'b0;
  logic [7:0]   fault_status = 8'd0;
  logic [31:0]  fault_addr = 32'd0;
  logic         flush_req;
  logic [1:0]   flush_op;
  logic         flush_ack = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  // Architectural model of the register file
  logic [31:0] m_sctlr, m_ttbr, m_dacr, m_far;
  logic [7:0]  m_fsr;

  always #5 clk = ~clk;

  core_cp15 #(.ID_CODE(ID_VAL), .SCTLR_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .transfer(transfer), .dec(dec), .write(write),
    .read(read), .done(done), .undefined(undefined), .busy(busy),
    .mmu_enable(mmu_enable), .align_check(align_check),
    .cache_enable(cache_enable), .high_vectors(high_vectors),
    .ttbr(ttbr), .dacr(dacr), .fault(fault), .fault_status(fault_status),
    .fault_addr(fault_addr), .flush_req(flush_req), .flush_op(flush_op),
    .flush_ack(flush_ack)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sctlr = 32'd0; m_ttbr = 32'd0; m_dacr = 32'd0; m_fsr = 8'd0; m_far = 32'd0;
  endtask

  // kind: 0 = undefined, 1 = register access, 2 = maintenance
  task automatic model_access(input logic [3:0] crn, input logic [3:0] crm, input logic [2:0] op1,
                              input logic [2:0] op2, input logic ld, output int kind, output logic [1:0] fop);
    kind = 0;
    fop  = 2'b00;
    if (op1 == 0) begin
      if ((crn == 0 || crn == 1 || crn == 2 || crn == 3 || crn == 5 || crn == 6) && crm == 0 && op2 == 0)
        kind = 1;
      else if (crn == 7 && !ld && op2 == 0 && crm >= 5 && crm <= 7) begin
        kind = 2;
        fop  = (crm == 5) ? 2'b00 : (crm == 6) ? 2'b01 : 2'b11;
      end else if (crn == 8 && !ld && op2 == 0 && crm == 7) begin
        kind = 2;
        fop  = 2'b10;
      end
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] crn);
    case (crn)
      4'd0: return ID_VAL;
      4'd1: return m_sctlr;
      4'd2: return m_ttbr;
      4'd3: return m_dacr;
      4'd5: return {24'd0, m_fsr};
      4'd6: return m_far;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] crn, input logic [31:0] w);
    case (crn)
      4'd1: m_sctlr = w & 32'h0000_2007;
      4'd2: m_ttbr  = w & 32'hFFFF_C000;
      4'd3: m_dacr  = w;
      4'd5: m_fsr   = w[7:0];
      4'd6: m_far   = w;
      default: ;
    endcase
  endtask

  task automatic chk_state();
    chk1("mmu_enable", mmu_enable, m_sctlr[0]);
    chk1("align_check", align_check, m_sctlr[1]);
    chk1("cache_enable", cache_enable, m_sctlr[2]);
    chk1("high_vectors", high_vectors, m_sctlr[13]);
    chk32("ttbr", ttbr, m_ttbr);
    chk32("dacr", dacr, m_dacr);
  endtask

  // One complete access; entered and left just after a negedge with the DUT idle
  task automatic access(input logic [3:0] crn, input logic [3:0] crm, input logic [2:0] op1,
                        input logic [2:0] op2, input logic ld, input logic [31:0] w,
                        input logic flt, input logic [7:0] fs, input logic [31:0] fa, input int ack_delay);
    int          kind;
    logic [1:0]  fop;
    logic [31:0] exp_rd;
    model_access(crn, crm, op1, op2, ld, kind, fop);
    exp_rd = (kind == 1 && ld) ? model_read(crn) : 32'd0;
    dec.crn = crn; dec.crm = crm; dec.op1 = op1; dec.op2 = op2; dec.load = ld;
    write = w;
    transfer = 1'b1;
    @(negedge clk);
    transfer = 1'b0;
    chk1("busy_after_transfer", busy, 1'b1);
    chk1("done_early", done, 1'b0);
    if (kind == 2) begin
      for (int k = 1; k <= ack_delay; k++) begin
        chk1("flush_req_held", flush_req, 1'b1);
        chk32("flush_op", {30'd0, flush_op}, {30'd0, fop});
        chk1("busy_in_flush", busy, 1'b1);
        chk1("done_in_flush", done, 1'b0);
        if (k == ack_delay) flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
      end
      chk1("flush_req_drop", flush_req, 1'b0);
      chk1("done_before_ack2", done, 1'b0);
      @(negedge clk);
      chk1("maint_done", done, 1'b1);
      chk1("maint_undefined", undefined, 1'b0);
      chk32("maint_read", read, 32'd0);
    end else begin
      chk1("flush_req_idle", flush_req, 1'b0);
      fault = flt; fault_status = fs; fault_addr = fa;
      @(negedge clk);
      fault = 1'b0;
      chk1("done", done, 1'b1);
      chk1("undefined", undefined, kind == 0);
      chk32("read", read, exp_rd);
      if (kind == 1 && !ld) model_write(crn, w);
      if (flt) begin m_fsr = fs; m_far = fa; end
      chk_state();
    end
    @(negedge clk);
    chk1("done_one_cycle", done, 1'b0);
    chk32("read_when_idle", read, 32'd0);
  endtask

  task automatic mrc(input logic [3:0] crn);
    access(crn, 4'd0, 3'd0, 3'd0, 1'b1, 32'd0, 1'b0, 8'd0, 32'd0, 1);
  endtask

  task automatic mcr(input logic [3:0] crn, input logic [31:0] w);
    access(crn, 4'd0, 3'd0, 3'd0, 1'b0, w, 1'b0, 8'd0, 32'd0, 1);
  endtask

  initial begin
    logic [3:0] crn_pool [11];
    crn_pool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd4, 4'd9, 4'd15};
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    chk32("rst_read", read, 32'd0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_flush_req", flush_req, 1'b0);
    chk32("rst_flush_op", {30'd0, flush_op}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_undefined", undefined, 1'b0);
    chk_state();

    // SCTLR: only M, A, C, V are writable
    mcr(4'd1, 32'hFFFF_FFFF);
    mrc(4'd1);
    chk1("sctlr_m", mmu_enable, 1'b1);
    chk1("sctlr_a", align_check, 1'b1);
    chk1("sctlr_c", cache_enable, 1'b1);
    chk1("sctlr_v", high_vectors, 1'b1);

    // TTBR low bits masked
    mcr(4'd2, 32'h1234_5FFF);
    chk32("ttbr_masked", ttbr, 32'h1234_4000);
    mrc(4'd2);

    // TLB invalidate with a slow acknowledge
    access(4'd8, 4'd7, 3'd0, 3'd0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, 5);

    // Fault capture beats a same-cycle MCR to FAR
    access(4'd6, 4'd0, 3'd0, 3'd0, 1'b0, 32'd0, 1'b1, 8'h35, 32'hDEAD_BEEF, 1);
    mrc(4'd6);
    mrc(4'd5);

    // Undefined encodings leave state untouched
    access(4'd1, 4'd0, 3'd1, 3'd0, 1'b1, 32'd0, 1'b0, 8'd0, 32'd0, 1);
    access(4'd7, 4'd5, 3'd0, 3'd0, 1'b1, 32'd0, 1'b0, 8'd0, 32'd0, 1);
    mrc(4'd1);

    // Ack outside FLUSH is ignored
    flush_ack = 1'b1;
    @(negedge clk);
    flush_ack = 1'b0;
    chk1("stray_ack_req", flush_req, 1'b0);
    chk1("stray_ack_done", done, 1'b0);

    // Reset in the middle of a flush
    dec.crn = 4'd7; dec.crm = 4'd7; dec.op1 = 3'd0; dec.op2 = 3'd0; dec.load = 1'b0;
    transfer = 1'b1;
    @(negedge clk);
    transfer = 1'b0;
    chk1("flush_before_rst", flush_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("rst_mid_flush_req", flush_req, 1'b0);
    chk1("rst_mid_flush_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("no_done_after_rst", done, 1'b0);
    end
    mrc(4'd0);
    chk_state();

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      logic [3:0] crn, crm;
      logic [2:0] op1, op2;
      logic       ld, flt;
      crn = crn_pool[$urandom_range(0, 10)];
      if ($urandom_range(0, 4) == 0) crm = 4'($urandom_range(0, 15));
      else if (crn == 4'd7)          crm = 4'($urandom_range(5, 7));
      else if (crn == 4'd8)          crm = 4'd7;
      else                           crm = 4'd0;
      op1 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      op2 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      ld  = (crn == 4'd7 || crn == 4'd8) ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
      flt = ($urandom_range(0, 4) == 0);
      access(crn, crm, op1, op2, ld, $urandom, flt, 8'($urandom), $urandom, $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        flush_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        flush_ack = 1'b0;
        chk1("idle_flush_req", flush_req, 1'b0);
      end
    end

    // Final register readback
    mrc(4'd1); mrc(4'd2); mrc(4'd3); mrc(4'd5); mrc(4'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
